// File: rtl/system_bus_pkg.sv
// Shared types and constants for the system bus arbiter family.
// Holds the FSM state encoding, default widths and the owner-index width helper.
package system_bus_pkg;

  localparam int DEF_NUM_MASTERS = 2;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_HOLD_CYCLES = 4;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_GRANT = ST_GRANT
  } state_e;

  // A two-master bus still needs one bit to name the owner.
  function automatic int owner_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/system_bus_arbiter_if.sv
// Request/grant and memory-command bundle between masters and the arbiter.
// SYSTEM_BUS_ARB_LOCK_EN adds the per-master bus_lock request qualifier.
interface system_bus_arbiter_if
  import system_bus_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W
);
  localparam int OWNER_W = owner_w(NUM_MASTERS);

  logic [NUM_MASTERS-1:0]        req;
  logic [NUM_MASTERS*ADDR_W-1:0] addr_in;
  logic [NUM_MASTERS*DATA_W-1:0] wdata_in;
  logic [NUM_MASTERS-1:0]        rw_in;
`ifdef SYSTEM_BUS_ARB_LOCK_EN
  logic [NUM_MASTERS-1:0]        bus_lock;
`endif

  logic [NUM_MASTERS-1:0] grant;
  logic [OWNER_W-1:0]     owner;
  logic                   busy;
  logic                   mem_valid;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic                   mem_rw;

`ifdef SYSTEM_BUS_ARB_LOCK_EN
  modport slave (
    input  req, addr_in, wdata_in, rw_in, bus_lock,
    output grant, owner, busy, mem_valid, mem_addr, mem_wdata, mem_rw
  );
  modport master (
    output req, addr_in, wdata_in, rw_in, bus_lock,
    input  grant, owner, busy, mem_valid, mem_addr, mem_wdata, mem_rw
  );
`else
  modport slave (
    input  req, addr_in, wdata_in, rw_in,
    output grant, owner, busy, mem_valid, mem_addr, mem_wdata, mem_rw
  );
  modport master (
    output req, addr_in, wdata_in, rw_in,
    input  grant, owner, busy, mem_valid, mem_addr, mem_wdata, mem_rw
  );
`endif

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer,
// wrapping past the top index back to zero.
module rr_pick #(
  parameter int NUM_MASTERS = 2,
  parameter int PTR_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [PTR_W-1:0]       pointer,
  output logic                   valid,
  output logic [PTR_W-1:0]       winner
);

  int idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = int'(pointer) + i;
      // Explicit wrap so non-power-of-two master counts rotate correctly.
      if (idx > NUM_MASTERS - 1) begin
        idx = idx - NUM_MASTERS;
      end
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/system_bus_arbiter.sv
// N-master round-robin bus arbiter with bounded tenure and registered memory command.
// Define SYSTEM_BUS_ARB_LOCK_EN to let a master hold the bus past HOLD_CYCLES via bus_lock.
module system_bus_arbiter
  import system_bus_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input logic                clk,
  input logic                rst,
  system_bus_arbiter_if.slave bus
);

  localparam int OWNER_W = owner_w(NUM_MASTERS);
  localparam int CNT_W   = $clog2(HOLD_CYCLES + 1);

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(HOLD_CYCLES);
  localparam logic [OWNER_W-1:0] LAST_IDX = OWNER_W'(NUM_MASTERS - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [OWNER_W-1:0]     ptr_q, ptr_d;
  logic [OWNER_W-1:0]     owner_q, owner_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic                   mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
  logic                   mem_rw_q, mem_rw_d;

  logic                   pick_valid;
  logic [OWNER_W-1:0]     pick_winner;
  logic                   owner_req;
  logic                   hold_exempt;
  logic                   tenure_done;

  logic [ADDR_W-1:0] addr_arr  [NUM_MASTERS];
  logic [DATA_W-1:0] wdata_arr [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_arr[i]  = bus.addr_in[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = bus.wdata_in[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_MASTERS(NUM_MASTERS),
    .PTR_W      (OWNER_W)
  ) u_pick (
    .req    (bus.req),
    .pointer(ptr_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign owner_req = bus.req[owner_q];

`ifdef SYSTEM_BUS_ARB_LOCK_EN
  assign hold_exempt = bus.bus_lock[owner_q];
`else
  assign hold_exempt = 1'b0;
`endif

  // A dropped request always ends the tenure, locked or not.
  assign tenure_done = !owner_req || (!hold_exempt && (cnt_q >= CNT_LAST));

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    mem_valid_d = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_rw_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          state_d = S_GRANT;
          owner_d = pick_winner;
          grant_d = NUM_MASTERS'(1) << pick_winner;
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        if (tenure_done) begin
          state_d = S_IDLE;
          grant_d = '0;
          cnt_d   = '0;
          ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + OWNER_W'(1);
        end else begin
          mem_valid_d = 1'b1;
          mem_addr_d  = addr_arr[owner_q];
          mem_wdata_d = wdata_arr[owner_q];
          mem_rw_d    = bus.rw_in[owner_q];
          // Saturates only while a lock holds the bus past the limit.
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      owner_q     <= '0;
      grant_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rw_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rw_q    <= mem_rw_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state_q == S_GRANT);
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_rw    = mem_rw_q;

endmodule

// File: tb/tb_system_bus_arbiter.sv
// Directed bench for system_bus_arbiter: a 4-master instance for the main checks
// and a 2-master instance for the default configuration.
module tb_system_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  system_bus_arbiter_if #(.NUM_MASTERS(4), .ADDR_W(8), .DATA_W(8)) bus4 ();
  system_bus_arbiter_if #(.NUM_MASTERS(2), .ADDR_W(8), .DATA_W(8)) bus2 ();

  system_bus_arbiter #(.NUM_MASTERS(4), .ADDR_W(8), .DATA_W(8), .HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave)
  );
  system_bus_arbiter #(.NUM_MASTERS(2), .ADDR_W(8), .DATA_W(8), .HOLD_CYCLES(4)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave)
  );

  logic [7:0] m_addr  [4] = '{8'h10, 8'h11, 8'h3C, 8'h13};
  logic [7:0] m_wdata [4] = '{8'h50, 8'h51, 8'hA5, 8'h53};
  logic [3:0] m_rw        = 4'b0110;

  typedef struct {
    logic       do_rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       valid;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       rw;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus4.req = '0;
    bus2.req = '0;
`ifdef SYSTEM_BUS_ARB_LOCK_EN
    bus4.bus_lock = '0;
    bus2.bus_lock = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(bus4.grant), 32'd0);
    check({tag, "_owner"}, 32'(bus4.owner), 32'd0);
    check({tag, "_busy"},  32'(bus4.busy), 32'd0);
    check({tag, "_valid"}, 32'(bus4.mem_valid), 32'd0);
    check({tag, "_addr"},  32'(bus4.mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(bus4.mem_wdata), 32'd0);
    check({tag, "_rw"},    32'(bus4.mem_rw), 32'd0);
  endtask

  // Structural invariants on both instances, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("onehot4", 32'($onehot0(bus4.grant)), 32'd1);
      check("owner_busy4", 32'(bus4.grant[bus4.owner]), 32'(bus4.busy));
      check("onehot2", 32'($onehot0(bus2.grant)), 32'd1);
      check("owner_busy2", 32'(bus2.grant[bus2.owner]), 32'(bus2.busy));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus4.req = '0;
    bus2.req = '0;
    bus4.rw_in = m_rw;
    for (int i = 0; i < 4; i++) begin
      bus4.addr_in[i*8 +: 8]  = m_addr[i];
      bus4.wdata_in[i*8 +: 8] = m_wdata[i];
    end
    bus2.addr_in  = 16'h2120;
    bus2.wdata_in = 16'h6160;
    bus2.rw_in    = 2'b01;
`ifdef SYSTEM_BUS_ARB_LOCK_EN
    bus4.bus_lock = '0;
    bus2.bus_lock = '0;
`endif

    #1;
    check_all_zero("reset_state");

    // do_rst, req, grant, owner, busy, valid, addr, wdata, rw, name
    vecs.push_back('{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, "single_grant"});
    vecs.push_back('{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 8'h3C, 8'hA5, 1'b1, "single_cmd1"});
    vecs.push_back('{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 8'h3C, 8'hA5, 1'b1, "single_cmd2"});
    vecs.push_back('{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 8'h3C, 8'hA5, 1'b1, "single_cmd3"});
    vecs.push_back('{1'b0, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "single_release"});
    vecs.push_back('{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, "single_regrant"});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "single_drop"});
    vecs.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "idle_hold"});
    vecs.push_back('{1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, "early_grant"});
    vecs.push_back('{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 8'h11, 8'h51, 1'b1, "early_cmd"});
    vecs.push_back('{1'b0, 4'b1001, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "early_release"});
    vecs.push_back('{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, "ptr_m3_first"});
    vecs.push_back('{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b1, 8'h13, 8'h53, 1'b0, "m3_cmd1"});
    vecs.push_back('{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b1, 8'h13, 8'h53, 1'b0, "m3_cmd2"});
    vecs.push_back('{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b1, 8'h13, 8'h53, 1'b0, "m3_cmd3"});
    vecs.push_back('{1'b0, 4'b1001, 4'b0000, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "m3_release"});
    vecs.push_back('{1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, "ptr_wrap_m0"});

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      bus4.req = vecs[i].req;
      step();
      check({vecs[i].name, "_grant"}, 32'(bus4.grant), 32'(vecs[i].grant));
      if (vecs[i].busy) check({vecs[i].name, "_owner"}, 32'(bus4.owner), 32'(vecs[i].owner));
      check({vecs[i].name, "_busy"},  32'(bus4.busy), 32'(vecs[i].busy));
      check({vecs[i].name, "_valid"}, 32'(bus4.mem_valid), 32'(vecs[i].valid));
      check({vecs[i].name, "_addr"},  32'(bus4.mem_addr), 32'(vecs[i].addr));
      check({vecs[i].name, "_wdata"}, 32'(bus4.mem_wdata), 32'(vecs[i].wdata));
      check({vecs[i].name, "_rw"},    32'(bus4.mem_rw), 32'(vecs[i].rw));
    end

    // Fairness: all four request continuously; 4 grant cycles then 1 idle per tenure.
    do_reset();
    bus4.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      for (int c = 0; c < ((t == 4) ? 1 : 5); c++) begin
        int ow;
        logic [3:0] eg;
        ow = t % 4;
        eg = (c < 4) ? 4'(1 << ow) : 4'b0000;
        step();
        check($sformatf("fair_t%0d_c%0d_grant", t, c), 32'(bus4.grant), 32'(eg));
        if (c < 4) check($sformatf("fair_t%0d_c%0d_owner", t, c), 32'(bus4.owner), 32'(ow));
        check($sformatf("fair_t%0d_c%0d_valid", t, c), 32'(bus4.mem_valid),
              32'((c > 0) && (c < 4)));
        check($sformatf("fair_t%0d_c%0d_addr", t, c), 32'(bus4.mem_addr),
              32'(((c > 0) && (c < 4)) ? m_addr[ow] : 8'h00));
      end
    end

    // Asynchronous reset two cycles into master 2's tenure, between clock edges.
    do_reset();
    bus4.req = 4'b0100;
    step();
    step();
    step();
    check("pre_rst_valid", 32'(bus4.mem_valid), 32'd1);
    check("pre_rst_addr", 32'(bus4.mem_addr), 32'h3C);
    check("pre_rst_owner", 32'(bus4.owner), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    bus4.req = 4'b1111;
    step();
    check("post_rst_grant", 32'(bus4.grant), 32'b0001);
    check("post_rst_owner", 32'(bus4.owner), 32'd0);

    // Two-master instance: continuous dual requests alternate owners 0,1,0.
    do_reset();
    bus2.req = 2'b11;
    for (int k = 1; k <= 11; k++) begin
      int pos;
      int t;
      logic [1:0] eg;
      pos = (k - 1) % 5;
      t   = (k - 1) / 5;
      eg  = (pos < 4) ? 2'(1 << (t % 2)) : 2'b00;
      step();
      check($sformatf("dual_k%0d_grant", k), 32'(bus2.grant), 32'(eg));
      if (pos < 4) check($sformatf("dual_k%0d_owner", k), 32'(bus2.owner), 32'(t % 2));
    end
    bus2.req = 2'b00;

`ifdef SYSTEM_BUS_ARB_LOCK_EN
    // Lock: master 0 holds the bus for 10 cycles, then master 1 after one idle cycle.
    do_reset();
    bus4.bus_lock = 4'b0001;
    bus4.req = 4'b0011;
    for (int k = 1; k <= 10; k++) begin
      step();
      check($sformatf("lock_k%0d_grant", k), 32'(bus4.grant), 32'b0001);
    end
    check("lock_valid_late", 32'(bus4.mem_valid), 32'd1);
    bus4.req = 4'b0010;
    step();
    check("lock_release_grant", 32'(bus4.grant), 32'b0000);
    step();
    check("lock_next_grant", 32'(bus4.grant), 32'b0010);
    check("lock_next_owner", 32'(bus4.owner), 32'd1);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/system_bus_arbiter.md
Name: system_bus_arbiter

Overview:
- Parametrised N-master shared-bus arbiter; successor to the fixed two-CPU bus.
- Grants one requester at a time using rotating round-robin priority and bounded tenure.
- Forwards the winner's address, write data and rw to registered memory-side outputs.
- Memory is instantiated by the parent, not by this block, so the arbiter works with any memory depth/width.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..16).
- ADDR_W, 8, address width per master.
- DATA_W, 8, write-data width per master.
- HOLD_CYCLES, 4, maximum GRANT-state cycles per tenure (1..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_MASTERS  request, bit i = master i.
- addr_in  in  NUM_MASTERS*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W].
- wdata_in  in  NUM_MASTERS*DATA_W  packed write data, same packing.
- rw_in  in  NUM_MASTERS  1 = write, 0 = read, per master.
- grant  out  NUM_MASTERS  one-hot grant (successor of enable0/enable1).
- owner  out  OWNER_W  index of granted master; OWNER_W = max(1, $clog2(NUM_MASTERS)).
- busy  out  1  high while in GRANT.
- mem_valid  out  1  memory-side command valid.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rw  out  1  memory write enable.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-tenure):
  - grant=0, owner=0, busy=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_rw=0.
  - State = IDLE, tenure counter = 0, priority pointer = 0 (master 0 highest).
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If req==0: stay in IDLE; all mem_* and grant outputs are 0.
  - If req!=0: the winner is the first set req bit searching upward from the pointer, wrapping modulo NUM_MASTERS.
  - At that edge: grant[winner]=1, owner=winner, busy=1, counter=0, go to GRANT.
  - Latency: req sampled high at edge k gives grant high in the cycle after edge k.
- GRANT:
  - Every edge registers addr_in/wdata_in/rw_in of the owner onto mem_*, with mem_valid=1.
  - mem_* lag the master's inputs by one cycle.
  - Counter increments each GRANT cycle.
- Tenure ends at the edge where either:
  - counter == HOLD_CYCLES-1, or
  - req[owner] is sampled low (early release).
- At tenure end:
  - Go to IDLE; grant, busy and mem_valid clear on that edge.
  - Pointer = (owner+1) mod NUM_MASTERS.
  - The mem_* command is not issued on the release edge.
- Turnaround: at least one IDLE cycle between tenures; back-to-back grants to different masters are separated by exactly one idle cycle.
- Simultaneous requests: round-robin from the pointer.
  - A master that keeps requesting after a full tenure is served again only after every other requester has been served once.
- Requests from non-owners during GRANT are ignored until IDLE; req is not latched.
- Arithmetic:
  - Counter width $clog2(HOLD_CYCLES+1).
  - Pointer wrap uses an explicit compare to NUM_MASTERS-1, not a power-of-two mask.
- Invariant: grant is always zero or one-hot, and grant[owner]==busy.

Optional Feature:
- Macro: SYSTEM_BUS_ARB_LOCK_EN.
- Defined:
  - Adds input bus_lock [NUM_MASTERS].
  - While bus_lock[owner] and req[owner] are both high, the HOLD_CYCLES limit is suppressed and the counter saturates, so tenure lasts until req[owner] drops.
  - Pointer update is unchanged.
- Undefined:
  - The port is absent and tenure is always bounded by HOLD_CYCLES.

Decomposition:
- Package system_bus_pkg holds:
  - State encoding localparams ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Function for OWNER_W.
  - Default width constants.
- Sub-module rr_pick:
  - Combinational round-robin priority picker.
  - Inputs: req, pointer. Outputs: valid, winner index.
  - Parametrised on NUM_MASTERS; reusable by future arbiters.

Test Plan:
- Reset mid-tenure: NUM_MASTERS=4; assert rst asynchronously two cycles into master 2's grant.
  - All outputs are 0 immediately, with no clock edge.
  - Afterwards req=4'b1111 grants master 0 first.
- Single requester: req=4'b0100, addr_in[2]=8'h3C, rw_in[2]=1, wdata 8'hA5.
  - grant=4'b0100 one cycle later.
  - mem_addr=8'h3C, mem_wdata=8'hA5, mem_rw=1, mem_valid=1 for HOLD_CYCLES-1 cycles.
  - Then IDLE for one cycle.
- Fairness: req=4'b1111 held constant.
  - Grant order 0,1,2,3,0 with exactly one idle cycle between tenures.
  - Each tenure is 4 cycles.
- Early release: master 1 granted; drop req[1] in its second GRANT cycle.
  - grant clears at the next edge.
  - Pointer=2, so pending master 3 is served before master 0.
- Two-master default (NUM_MASTERS=2, 8-bit):
  - Alternating grants under continuous dual requests.
  - owner toggles 0,1,0; grant is never two-hot (assertion).
- Lock (with SYSTEM_BUS_ARB_LOCK_EN): bus_lock[0]=1, req[0] held for 10 cycles, req[1]=1.
  - Master 0 keeps the grant for all 10 cycles.
  - Master 1 is granted after one idle cycle.
